cfg_respfifo: RTL and testbench
===============================

# cfg_respfifo

Response-side counterpart of the config command FIFO. It accepts config responses from the config decode logic, buffers them in a DEPTH-entry FIFO, and transmits them to the TLX under TLX-issued response credits. Read data is driven one cycle after the response header, matching the TLX config response interface. It sits between the config space decoder and the TLX `cfg_tlx_resp_*` / `cfg_tlx_rdata_*` ports.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, 2..16.
- `WIDTH`, default 64: packed entry width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tlx_is_ready`  in  1  TLX initialised; no launch while 0.
- `tlx_cfg_resp_initial_credit`  in  4  response credits granted at TLX ready.
- `tlx_cfg_resp_credit`  in  1  pulse; returns one response credit.
- `rsp_in_valid`  in  1  push a response.
- `rsp_in_opcode`  in  8  response opcode.
- `rsp_in_capptag`  in  16  capptag.
- `rsp_in_code`  in  4  response code.
- `rsp_in_rdata_valid`  in  1  response carries read data.
- `rsp_in_rdata_bdi`  in  1  bad data indicator.
- `rsp_in_rdata_bus`  in  32  read data.
- `rsp_space_avail`  out  1  1 when the FIFO can accept a push this cycle.
- `cfg_tlx_resp_valid`  out  1  header valid pulse.
- `cfg_tlx_resp_opcode` / `_capptag` / `_code`  out  8/16/4  header fields.
- `cfg_tlx_rdata_valid`  out  1  data valid; one cycle after the header.
- `cfg_tlx_rdata_bdi`  out  1  data bad indicator.
- `cfg_tlx_rdata_bus`  out  32  read data.
- `fifo_overflow`  out  1  pulse: push while full.
- `credit_overflow`  out  1  pulse: credit return with the counter at 15.

## Operation
- Entry packing, MSB to LSB: opcode, capptag, code, 2'b00 pad, rdata_valid, bdi, 32-bit data (64 bits total).
- Write pointer, read pointer, and a per-entry valid vector. Pointers wrap DEPTH-1 → 0.
- Push when `rsp_in_valid`=1 and not full: write at wrptr, set valid, increment wrptr.
- Push while full: the entry is dropped, no pointer or valid change, and `fifo_overflow`=1 that cycle.
- `rsp_space_avail` = count < DEPTH.
- Credit counter, 4 bits. On the first cycle where `tlx_is_ready`=1 (registered rising edge), it loads `tlx_cfg_resp_initial_credit`. Before that it holds 0.
- A launch occurs when the head is valid, credits > 0, and `tlx_is_ready`=1. A launch pops the head (clears its valid, increments rdptr) and decrements credits.
- Credit return and launch in the same cycle: counter unchanged.
- Credit return at 15: counter stays 15 and `credit_overflow`=1 that cycle.
- Push and launch in the same cycle are both honoured. A push to a full FIFO during a pop is still dropped (fullness is evaluated before the pop).
- Two-stage output pipeline:
  - Header stage registers the popped opcode/capptag/code and `resp_valid`.
  - Data stage registers rdata_valid/bdi/bus one cycle later.
  - Entries with rdata_valid=0 produce `cfg_tlx_rdata_valid`=0, and bus/bdi are driven to 0.
- Back-to-back launches are allowed: one header per cycle.
- When not valid, all header and data outputs are driven to 0.

## Timing
- Reset values: all outputs 0, FIFO empty, credits 0, pointers 0, `rsp_space_avail`=1.
- Latency, push to header: push sampled at edge N; entry valid after edge N; header registered at edge N+1; `cfg_tlx_resp_valid` high in cycle N+1..N+2. Read data follows one cycle later.
- `tlx_is_ready` falling mid-stream: no new launch; the in-flight data stage still completes; credits are held.
- Async reset mid-operation: all state is cleared immediately, and in-flight header/data are abandoned.

## Configuration
- `CFG_RESPFIFO_BYPASS_EN` defined: when the FIFO is empty and a launch is possible, the incoming push writes the header stage directly and skips the array. Header appears in the cycle after the push (latency 1), and the FIFO stays empty.
- Not defined: every response passes through the array (latency 2). Ordering is identical in both builds.

## Structure
- Shared package `cfg_pkg`: entry field offsets, `CFG_RESP_ENTRY_W`=64, credit counter width 4.
- Sub-module `cfg_respfifo_array`: storage, pointers, valid vector, full/empty. The top level holds the credit counter, launch logic and output pipeline.

## Test plan
- **Credit-gated launch:** reset, `tlx_is_ready`=1, initial credit 2, push 3 responses (capptag 0x0001..0x0003) → exactly 2 headers, in order. Then one `tlx_cfg_resp_credit` pulse → the third header issues 1 cycle later.
- **Data alignment:** push opcode 0x01, rdata_valid=1, data 0xDEADBEEF → `cfg_tlx_rdata_valid` and bus 0xDEADBEEF exactly 1 cycle after `cfg_tlx_resp_valid`. A response with rdata_valid=0 gives rdata_valid low and bus 0.
- **Full/wrap:** credits 0, push 9 → `rsp_space_avail`=0 after 8 pushes, `fifo_overflow` pulses on the 9th. Then grant 15 credits → 8 headers in order, across the pointer wrap.
- **Simultaneous events:** credit return and launch in the same cycle → counter unchanged. 15 credits plus one return → `credit_overflow` pulse, counter stays 15.
- **Reset mid-stream:** assert `reset_n`=0 during a header cycle → all outputs 0 immediately. After release, no stale response is emitted.
- **Bypass (`CFG_RESPFIFO_BYPASS_EN`):** empty FIFO, credit 1, push → header appears 1 cycle after the push. Without the macro → 2 cycles.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the config response path.
//   - CFG_RESP_ENTRY_W : packed response entry width (64)
//   - CFG_CRED_W       : response credit counter width (4)
//   - cfg_resp_t       : packed entry layout, MSB to LSB:
//                        opcode, capptag, code, 2'b00 pad, rdata_valid, bdi, data
//   - field offsets of cfg_resp_t for code that works on raw vectors
package cfg_pkg;
   localparam int CFG_RESP_ENTRY_W = 64;
   localparam int CFG_CRED_W       = 4;

   localparam int CFG_OPC_LSB      = 56;
   localparam int CFG_CAPPTAG_LSB  = 40;
   localparam int CFG_CODE_LSB     = 36;
   localparam int CFG_RDV_BIT      = 33;
   localparam int CFG_BDI_BIT      = 32;
   localparam int CFG_DATA_LSB     = 0;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] capptag;
      logic [3:0]  code;
      logic [1:0]  pad;
      logic        rdata_valid;
      logic        bdi;
      logic [31:0] data;
   } cfg_resp_t;
endpackage

// File: rtl/cfg_respfifo_if.sv
// cfg_respfifo_if: bundles the response push side (config decoder) and the
// TLX response/credit side of cfg_respfifo.
//   master : the environment (decoder + TLX) driving pushes and credits
//   slave  : the response FIFO
interface cfg_respfifo_if;
   logic        tlx_is_ready;
   logic [3:0]  tlx_cfg_resp_initial_credit;
   logic        tlx_cfg_resp_credit;
   logic        rsp_in_valid;
   logic [7:0]  rsp_in_opcode;
   logic [15:0] rsp_in_capptag;
   logic [3:0]  rsp_in_code;
   logic        rsp_in_rdata_valid;
   logic        rsp_in_rdata_bdi;
   logic [31:0] rsp_in_rdata_bus;
   logic        rsp_space_avail;
   logic        cfg_tlx_resp_valid;
   logic [7:0]  cfg_tlx_resp_opcode;
   logic [15:0] cfg_tlx_resp_capptag;
   logic [3:0]  cfg_tlx_resp_code;
   logic        cfg_tlx_rdata_valid;
   logic        cfg_tlx_rdata_bdi;
   logic [31:0] cfg_tlx_rdata_bus;
   logic        fifo_overflow;
   logic        credit_overflow;

   modport master (
      output tlx_is_ready, tlx_cfg_resp_initial_credit, tlx_cfg_resp_credit,
             rsp_in_valid, rsp_in_opcode, rsp_in_capptag, rsp_in_code,
             rsp_in_rdata_valid, rsp_in_rdata_bdi, rsp_in_rdata_bus,
      input  rsp_space_avail, cfg_tlx_resp_valid, cfg_tlx_resp_opcode,
             cfg_tlx_resp_capptag, cfg_tlx_resp_code, cfg_tlx_rdata_valid,
             cfg_tlx_rdata_bdi, cfg_tlx_rdata_bus, fifo_overflow, credit_overflow
   );

   modport slave (
      input  tlx_is_ready, tlx_cfg_resp_initial_credit, tlx_cfg_resp_credit,
             rsp_in_valid, rsp_in_opcode, rsp_in_capptag, rsp_in_code,
             rsp_in_rdata_valid, rsp_in_rdata_bdi, rsp_in_rdata_bus,
      output rsp_space_avail, cfg_tlx_resp_valid, cfg_tlx_resp_opcode,
             cfg_tlx_resp_capptag, cfg_tlx_resp_code, cfg_tlx_rdata_valid,
             cfg_tlx_rdata_bdi, cfg_tlx_rdata_bus, fifo_overflow, credit_overflow
   );
endinterface

// File: rtl/cfg_respfifo_array.sv
// cfg_respfifo_array: DEPTH-entry storage with write/read pointers and a
// per-entry valid vector.
//   clock, reset_n : clock, async active-low reset
//   i_push, i_wdata: write request; ignored while full
//   i_pop          : remove head; ignored while empty
//   o_head         : head entry contents
//   o_head_valid   : head holds an entry (i.e. not empty)
//   o_full         : no free slot
module cfg_respfifo_array #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_head_valid,
   output logic             o_full
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_wrptr;
   logic [PW-1:0]    r_rdptr;
   logic             w_wr;
   logic             w_rd;

   // In a ring, the slot under wrptr is occupied only when every slot is.
   assign o_full       = r_vld[r_wrptr];
   assign o_head_valid = r_vld[r_rdptr];
   assign o_head       = r_mem[r_rdptr];
   assign w_wr         = i_push & ~o_full;
   assign w_rd         = i_pop & o_head_valid;

   // Write and read slots never coincide: a write needs a free wrptr slot,
   // a read needs an occupied rdptr slot, and equal pointers mean one of
   // the two is impossible.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vld   <= '0;
         r_wrptr <= '0;
         r_rdptr <= '0;
      end else begin
         if (w_wr) begin
            r_vld[r_wrptr] <= 1'b1;
            r_wrptr        <= r_wrptr + 1'b1;
         end
         if (w_rd) begin
            r_vld[r_rdptr] <= 1'b0;
            r_rdptr        <= r_rdptr + 1'b1;
         end
      end
   end

   // Storage has no reset; the valid vector guards every read.
   always_ff @(posedge clock) begin
      if (w_wr) r_mem[r_wrptr] <= i_wdata;
   end
endmodule

// File: rtl/cfg_respfifo.sv
// cfg_respfifo: buffers config responses and launches them to the TLX under
// response credits. Header goes out on cfg_tlx_resp_*, read data follows one
// cycle later on cfg_tlx_rdata_*.
//   clock, reset_n : clock, async active-low reset
//   io (slave)     : push side (rsp_in_*, rsp_space_avail), TLX side
//                    (tlx_is_ready, credits, cfg_tlx_*), overflow pulses
// Build option: CFG_RESPFIFO_BYPASS_EN -- a push into an empty FIFO that can
// launch right away goes straight to the header stage (latency 1 instead of 2).
module cfg_respfifo
   import cfg_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = CFG_RESP_ENTRY_W
) (
   input  logic          clock,
   input  logic          reset_n,
   cfg_respfifo_if.slave io
);
   localparam logic [CFG_CRED_W-1:0] CRED_MAX = {CFG_CRED_W{1'b1}};

   cfg_resp_t             w_in;
   cfg_resp_t             w_head;
   cfg_resp_t             w_sel;
   logic [WIDTH-1:0]      w_wdata;
   logic [WIDTH-1:0]      w_head_raw;
   logic                  w_head_vld;
   logic                  w_full;
   logic                  w_push;
   logic                  w_launch;
   logic                  w_byp;
   logic                  w_send;
   logic                  w_can_send;
   logic                  w_load;
   logic                  w_ret;
   logic                  w_sel_rdv;

   logic                  r_ready_q;
   logic [CFG_CRED_W-1:0] r_cred;

   logic                  r_hdr_vld;
   logic [7:0]            r_hdr_opc;
   logic [15:0]           r_hdr_tag;
   logic [3:0]            r_hdr_code;
   logic                  r_hdr_rdv;
   logic                  r_hdr_bdi;
   logic [31:0]           r_hdr_data;

   logic                  r_dat_vld;
   logic                  r_dat_bdi;
   logic [31:0]           r_dat_bus;

   assign w_in.opcode      = io.rsp_in_opcode;
   assign w_in.capptag     = io.rsp_in_capptag;
   assign w_in.code        = io.rsp_in_code;
   assign w_in.pad         = 2'b00;
   assign w_in.rdata_valid = io.rsp_in_rdata_valid;
   assign w_in.bdi         = io.rsp_in_rdata_bdi;
   assign w_in.data        = io.rsp_in_rdata_bus;

   assign w_wdata = WIDTH'(w_in);
   assign w_head  = cfg_resp_t'(w_head_raw[CFG_RESP_ENTRY_W-1:0]);

   // Credits are (re)loaded on the ready rising edge. Launches wait for the
   // loaded value so stale credits from an earlier ready period are never
   // spent.
   assign w_load     = io.tlx_is_ready & ~r_ready_q;
   assign w_can_send = io.tlx_is_ready & r_ready_q & (r_cred != '0);
   assign w_launch   = w_head_vld & w_can_send;

`ifdef CFG_RESPFIFO_BYPASS_EN
   // Empty FIFO means nothing older can be waiting, so order is preserved.
   assign w_byp = io.rsp_in_valid & ~w_head_vld & w_can_send;
`else
   assign w_byp = 1'b0;
`endif

   assign w_send    = w_launch | w_byp;
   assign w_sel     = w_launch ? w_head : w_in;
   assign w_sel_rdv = w_send & w_sel.rdata_valid;
   assign w_push    = io.rsp_in_valid & ~w_byp;
   assign w_ret     = io.tlx_cfg_resp_credit;

   cfg_respfifo_array #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_array (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_push       (w_push),
      .i_wdata      (w_wdata),
      .i_pop        (w_launch),
      .o_head       (w_head_raw),
      .o_head_valid (w_head_vld),
      .o_full       (w_full)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ready_q <= 1'b0;
         r_cred    <= '0;
      end else begin
         r_ready_q <= io.tlx_is_ready;
         if (w_load)
            r_cred <= io.tlx_cfg_resp_initial_credit;
         else if (w_ret && !w_send && r_cred != CRED_MAX)
            r_cred <= r_cred + 1'b1;
         else if (!w_ret && w_send)
            r_cred <= r_cred - 1'b1;
      end
   end

   // Header stage, then data stage one cycle behind. Fields are zeroed
   // whenever their stage is idle or the entry carries no read data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hdr_vld  <= 1'b0;
         r_hdr_opc  <= '0;
         r_hdr_tag  <= '0;
         r_hdr_code <= '0;
         r_hdr_rdv  <= 1'b0;
         r_hdr_bdi  <= 1'b0;
         r_hdr_data <= '0;
         r_dat_vld  <= 1'b0;
         r_dat_bdi  <= 1'b0;
         r_dat_bus  <= '0;
      end else begin
         r_hdr_vld  <= w_send;
         r_hdr_opc  <= w_send ? w_sel.opcode  : '0;
         r_hdr_tag  <= w_send ? w_sel.capptag : '0;
         r_hdr_code <= w_send ? w_sel.code    : '0;
         r_hdr_rdv  <= w_sel_rdv;
         r_hdr_bdi  <= w_sel_rdv & w_sel.bdi;
         r_hdr_data <= w_sel_rdv ? w_sel.data : '0;
         r_dat_vld  <= r_hdr_vld & r_hdr_rdv;
         r_dat_bdi  <= r_hdr_bdi;
         r_dat_bus  <= r_hdr_data;
      end
   end

   assign io.rsp_space_avail      = ~w_full;
   assign io.fifo_overflow        = io.rsp_in_valid & w_full;
   assign io.credit_overflow      = w_ret & ~w_send & (r_cred == CRED_MAX);
   assign io.cfg_tlx_resp_valid   = r_hdr_vld;
   assign io.cfg_tlx_resp_opcode  = r_hdr_opc;
   assign io.cfg_tlx_resp_capptag = r_hdr_tag;
   assign io.cfg_tlx_resp_code    = r_hdr_code;
   assign io.cfg_tlx_rdata_valid  = r_dat_vld;
   assign io.cfg_tlx_rdata_bdi    = r_dat_bdi;
   assign io.cfg_tlx_rdata_bus    = r_dat_bus;
endmodule

// File: tb/tb_cfg_respfifo.sv
module tb_cfg_respfifo;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   cfg_respfifo_if bus();

   cfg_respfifo #(.DEPTH(8), .WIDTH(64)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .io      (bus)
   );

`ifdef CFG_RESPFIFO_BYPASS_EN
   localparam int BLAT = 0;
`else
   localparam int BLAT = 1;
`endif

   typedef struct {
      logic [7:0]  opc;
      logic [15:0] tag;
      logic [3:0]  code;
      logic        rdv;
      logic        bdi;
      logic [31:0] data;
      int          pcyc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   hdr_cnt = 0;
   int   last_hdr_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor: data stage checked against the header seen one cycle earlier.
   exp_t pend_e;
   bit   pend = 1'b0;
   always @(negedge clock) begin
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("rdata_valid", 64'(bus.cfg_tlx_rdata_valid), 64'(pend_e.rdv));
            chk("rdata_bdi", 64'(bus.cfg_tlx_rdata_bdi), 64'(pend_e.rdv & pend_e.bdi));
            chk("rdata_bus", 64'(bus.cfg_tlx_rdata_bus), pend_e.rdv ? 64'(pend_e.data) : 64'd0);
         end else if (bus.cfg_tlx_rdata_valid || bus.cfg_tlx_rdata_bdi || bus.cfg_tlx_rdata_bus != 0) begin
            chk("idle_rdata", 64'({bus.cfg_tlx_rdata_valid, bus.cfg_tlx_rdata_bdi, bus.cfg_tlx_rdata_bus}), 64'd0);
         end
         pend = 1'b0;
         if (bus.cfg_tlx_resp_valid) begin
            hdr_cnt++;
            last_hdr_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexp_hdr", 64'(bus.cfg_tlx_resp_valid), 64'd0);
            end else begin
               pend_e = sb.pop_front();
               chk("hdr", 64'({bus.cfg_tlx_resp_opcode, bus.cfg_tlx_resp_capptag, bus.cfg_tlx_resp_code}),
                   64'({pend_e.opc, pend_e.tag, pend_e.code}));
               if (pend_e.lat >= 0) chk("hdr_lat", 64'(cyc - pend_e.pcyc), 64'(pend_e.lat));
               pend = 1'b1;
            end
         end else if (bus.cfg_tlx_resp_opcode != 0 || bus.cfg_tlx_resp_capptag != 0 || bus.cfg_tlx_resp_code != 0) begin
            chk("idle_hdr", 64'({bus.cfg_tlx_resp_opcode, bus.cfg_tlx_resp_capptag, bus.cfg_tlx_resp_code}), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [7:0] opc, input logic [15:0] tag, input logic [3:0] code,
                         input logic rdv, input logic bdi, input logic [31:0] data);
      bus.rsp_in_valid       = 1'b1;
      bus.rsp_in_opcode      = opc;
      bus.rsp_in_capptag     = tag;
      bus.rsp_in_code        = code;
      bus.rsp_in_rdata_valid = rdv;
      bus.rsp_in_rdata_bdi   = bdi;
      bus.rsp_in_rdata_bus   = data;
   endtask

   task automatic sb_add(input logic [7:0] opc, input logic [15:0] tag, input logic [3:0] code,
                         input logic rdv, input logic bdi, input logic [31:0] data, input int lat);
      exp_t e;
      e.opc = opc; e.tag = tag; e.code = code;
      e.rdv = rdv; e.bdi = bdi; e.data = data;
      e.pcyc = cyc; e.lat = lat;
      sb.push_back(e);
   endtask

   // Push sampled at the next edge; expected entry queued with that edge.
   task automatic push(input logic [7:0] opc, input logic [15:0] tag, input logic [3:0] code,
                       input logic rdv, input logic bdi, input logic [31:0] data, input int lat);
      set_in(opc, tag, code, rdv, bdi, data);
      tick();
      bus.rsp_in_valid = 1'b0;
      sb_add(opc, tag, code, rdv, bdi, data, lat);
   endtask

   task automatic reload(input logic [3:0] c);
      bus.tlx_is_ready = 1'b0;
      tick();
      bus.tlx_cfg_resp_initial_credit = c;
      bus.tlx_is_ready = 1'b1;
      tick();
   endtask

   task automatic wait_hdrs(input int target, input int budget);
      int k = 0;
      while (hdr_cnt < target && k < budget) begin
         tick();
         k++;
      end
      repeat (3) tick();
      chk("hdr_count", 64'(hdr_cnt), 64'(target));
   endtask

   task automatic chk_idle_outs(input string name);
      chk(name, 64'({bus.cfg_tlx_resp_valid, bus.cfg_tlx_resp_opcode, bus.cfg_tlx_resp_capptag,
                     bus.cfg_tlx_resp_code, bus.cfg_tlx_rdata_valid, bus.cfg_tlx_rdata_bdi,
                     bus.fifo_overflow, bus.credit_overflow}), 64'd0);
      chk({name, "_bus"}, 64'(bus.cfg_tlx_rdata_bus), 64'd0);
      chk({name, "_space"}, 64'(bus.rsp_space_avail), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

   initial begin
      int base;
      int e_cyc;
      int k;
      bus.tlx_is_ready = 1'b0;
      bus.tlx_cfg_resp_initial_credit = 4'd0;
      bus.tlx_cfg_resp_credit = 1'b0;
      bus.rsp_in_valid = 1'b0;
      bus.rsp_in_opcode = '0;
      bus.rsp_in_capptag = '0;
      bus.rsp_in_code = '0;
      bus.rsp_in_rdata_valid = 1'b0;
      bus.rsp_in_rdata_bdi = 1'b0;
      bus.rsp_in_rdata_bus = '0;

      // Reset state
      #2;
      chk_idle_outs("reset");
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Credit-gated launch: 2 credits, 3 pushes
      reload(4'd2);
      push(8'h20, 16'h0001, 4'h0, 1'b0, 1'b0, 32'h0, BLAT);
      push(8'h20, 16'h0002, 4'h0, 1'b0, 1'b0, 32'h0, BLAT);
      push(8'h20, 16'h0003, 4'h0, 1'b0, 1'b0, 32'h0, -1);
      repeat (6) tick();
      chk("gated_cnt", 64'(hdr_cnt), 64'd2);
      bus.tlx_cfg_resp_credit = 1'b1;
      tick();
      e_cyc = cyc;
      bus.tlx_cfg_resp_credit = 1'b0;
      wait_hdrs(3, 10);
      chk("cred_lat", 64'(last_hdr_cyc - e_cyc), 64'd1);

      // Data alignment
      reload(4'd4);
      push(8'h01, 16'h0010, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF, BLAT);
      push(8'h02, 16'h0011, 4'h3, 1'b0, 1'b1, 32'h12345678, BLAT);
      push(8'h03, 16'h0012, 4'hE, 1'b1, 1'b1, 32'hCAFEF00D, BLAT);
      wait_hdrs(6, 10);

      // Full / overflow / wrap
      reload(4'd0);
      for (int i = 0; i < 8; i++) begin
         chk("space_avail", 64'(bus.rsp_space_avail), 64'd1);
         push(8'h40 + 8'(i), 16'h0100 + 16'(i), 4'(i), 1'(i), 1'b0, 32'hA0000000 + 32'(i), -1);
      end
      chk("space_full", 64'(bus.rsp_space_avail), 64'd0);
      set_in(8'hFF, 16'hFFFF, 4'hF, 1'b1, 1'b1, 32'hFFFFFFFF);
      #1;
      chk("fifo_ovf", 64'(bus.fifo_overflow), 64'd1);
      tick();
      bus.rsp_in_valid = 1'b0;
      #1;
      chk("fifo_ovf_clr", 64'(bus.fifo_overflow), 64'd0);
      reload(4'd15);
      wait_hdrs(14, 20);
      chk("space_drained", 64'(bus.rsp_space_avail), 64'd1);

      // Credit return coinciding with a launch
      reload(4'd1);
      set_in(8'h50, 16'h0200, 4'h1, 1'b1, 1'b0, 32'h11111111);
`ifdef CFG_RESPFIFO_BYPASS_EN
      bus.tlx_cfg_resp_credit = 1'b1;
`endif
      #1;
      chk("cred_ovf_low", 64'(bus.credit_overflow), 64'd0);
      tick();
      sb_add(8'h50, 16'h0200, 4'h1, 1'b1, 1'b0, 32'h11111111, BLAT);
      set_in(8'h51, 16'h0201, 4'h2, 1'b0, 1'b0, 32'h0);
`ifndef CFG_RESPFIFO_BYPASS_EN
      bus.tlx_cfg_resp_credit = 1'b1;
`else
      bus.tlx_cfg_resp_credit = 1'b0;
`endif
      tick();
      bus.tlx_cfg_resp_credit = 1'b0;
      bus.rsp_in_valid = 1'b0;
      sb_add(8'h51, 16'h0201, 4'h2, 1'b0, 1'b0, 32'h0, BLAT);
      wait_hdrs(16, 10);

      // Credit overflow at 15, counter holds 15
      reload(4'd15);
      bus.tlx_cfg_resp_credit = 1'b1;
      #1;
      chk("cred_ovf", 64'(bus.credit_overflow), 64'd1);
      tick();
      bus.tlx_cfg_resp_credit = 1'b0;
      #1;
      chk("cred_ovf_clr", 64'(bus.credit_overflow), 64'd0);
      bus.tlx_cfg_resp_credit = 1'b1;
      #1;
      chk("cred_ovf_hold", 64'(bus.credit_overflow), 64'd1);
      tick();
      bus.tlx_cfg_resp_credit = 1'b0;

      // Reset mid-stream with entries still queued
      bus.tlx_is_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++)
         push(8'h60 + 8'(i), 16'h0300 + 16'(i), 4'h7, 1'b1, 1'b0, 32'hB0000000 + 32'(i), -1);
      bus.tlx_cfg_resp_initial_credit = 4'd1;
      bus.tlx_is_ready = 1'b1;
      tick();
      k = 0;
      while (!bus.cfg_tlx_resp_valid && k < 10) begin
         @(negedge clock);
         k++;
      end
      chk("mid_hdr_seen", 64'(bus.cfg_tlx_resp_valid), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk_idle_outs("mid_reset");
      sb.delete();
      tick(); tick();
      reset_n = 1'b1;
      base = hdr_cnt;
      repeat (8) tick();
      chk("no_stale", 64'(hdr_cnt), 64'(base));

      // Single push into an empty FIFO with one credit: latency check
      push(8'h55, 16'h0ABC, 4'h5, 1'b1, 1'b0, 32'h0BADF00D, BLAT);
      wait_hdrs(base + 1, 10);
      chk("space_end", 64'(bus.rsp_space_avail), 64'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
